// File: rtl/cost_sched_pkg.sv
// cost_sched_pkg: shared types, widths and the permutation slice helper for cost_eval_sched.
package cost_sched_pkg;
  localparam int WORKERS = 8;
  localparam int COST_W = 7;
  localparam int SUM_W = 10;
  localparam int PERM_W = 3 * WORKERS;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  function automatic logic [2:0] perm_job(input logic [PERM_W-1:0] perm, input logic [2:0] idx);
    return perm[3*idx +: 3];
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last-served pointer resets to engine 1 so engine 0 wins the first tie.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] valid,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);
  logic last;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) last <= 1'b1;
    else if (upd) last <= upd_id;
  assign grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/cost_eval_sched.sv
// cost_eval_sched: shares one cost ROM between two search engines, summing eight reads per permutation.
// Optional early abort on bound overrun when COSTSCHED_EARLY_ABORT_EN is defined.
module cost_eval_sched
  import cost_sched_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [47:0] req_perm,
  input  logic [19:0] req_bound,
  output logic [2:0]  W,
  output logic [2:0]  J,
  input  logic [6:0]  Cost,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [9:0]  rsp_sum,
  output logic        rsp_abort,
  output logic        busy
);
  state_t state, nxt;
  logic [1:0] grant;
  logic [PERM_W-1:0] perm, sel_perm;
  logic [2:0] idx;
  logic [SUM_W-1:0] acc, sum;
  logic owner, hs, rsp_done, abort_hit, stop;
  assign sel_perm = grant[1] ? req_perm[47:24] : req_perm[23:0];
  assign sum = acc + {{(SUM_W-COST_W){1'b0}}, Cost};
  assign hs = state == IDLE && |grant;
  assign rsp_done = state == RESP && rsp_ready[owner];
  assign stop = idx == 3'd7 || abort_hit;
  assign rsp_sum = acc;
  rr_arb2 u_arb (
    .CLK(CLK),
    .RST_N(RST_N),
    .valid(req_valid),
    .upd(rsp_done),
    .upd_id(owner),
    .grant(grant)
  );
`ifdef COSTSCHED_EARLY_ABORT_EN
  logic [SUM_W-1:0] bound;
  logic abort_q;
  assign abort_hit = state == RUN && sum > bound;
  assign rsp_abort = abort_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      bound <= '0;
      abort_q <= 1'b0;
    end else if (hs) begin
      bound <= grant[1] ? req_bound[19:10] : req_bound[9:0];
      abort_q <= 1'b0;
    end else if (state == RUN) abort_q <= abort_hit;
`else
  logic bound_unused;
  assign bound_unused = ^req_bound;
  assign abort_hit = 1'b0;
  assign rsp_abort = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (hs ? RUN : IDLE) :
          state == RUN  ? (stop ? RESP : RUN) :
          (rsp_ready[owner] ? IDLE : RESP);
  // req_ready is gated by RST_N so nothing looks accepted while reset is held
  always_comb begin
    req_ready = (state == IDLE && RST_N) ? grant : 2'b00;
    rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    busy = state != IDLE;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      perm <= '0;
      owner <= 1'b0;
      acc <= '0;
      idx <= '0;
      W <= '0;
      J <= '0;
    end else if (hs) begin
      perm <= sel_perm;
      owner <= grant[1];
      acc <= '0;
      idx <= '0;
      W <= '0;
      J <= perm_job(sel_perm, 3'd0);
    end else if (state == RUN) begin
      acc <= sum;
      if (!stop) begin
        idx <= idx + 3'd1;
        W <= idx + 3'd1;
        J <= perm_job(perm, idx + 3'd1);
      end
    end
endmodule

// File: tb/tb_cost_eval_sched.sv
// tb_cost_eval_sched: directed and random jobs against a sum-of-products reference with Cost = W*J.
module tb_cost_eval_sched;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [47:0] req_perm = '0;
  logic [19:0] req_bound = '0;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [9:0] rsp_sum;
  logic rsp_abort, busy;
  int n_vec = 0;
  int n_err = 0;
  logic [23:0] perm_s[2];
  logic [9:0] bound_s[2];

  always #5 CLK = ~CLK;
  assign Cost = 7'(W) * 7'(J);

  cost_eval_sched dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_perm(req_perm), .req_bound(req_bound), .W(W), .J(J), .Cost(Cost),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_abort(rsp_abort), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: weighted sum of worker index times assigned job, stopping once the bound is exceeded
  function automatic void model(input logic [23:0] p, input logic [9:0] b,
                                output int n, output int s, output bit ab);
    bit en;
`ifdef COSTSCHED_EARLY_ABORT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    s = 0;
    ab = 1'b0;
    n = 8;
    for (int i = 0; i < 8; i++) begin
      s += i * int'(p[3*i +: 3]);
      if (en && s > int'(b)) begin
        ab = 1'b1;
        n = i + 1;
        return;
      end
    end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_W"}, 32'(W), 0);
    chk({tag, "_J"}, 32'(J), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_sum"}, 32'(rsp_sum), 0);
    chk({tag, "_rsp_abort"}, 32'(rsp_abort), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic run_job(input int eng, input int hold, input bit drop);
    int n, s;
    bit ab;
    logic [2:0] w0, j0;
    logic [9:0] s0;
    req_perm = {perm_s[1], perm_s[0]};
    req_bound = {bound_s[1], bound_s[0]};
    model(perm_s[eng], bound_s[eng], n, s, ab);
    #1;
    chk("grant", 32'(req_ready), eng ? 2 : 1);
    chk("busy_idle", 32'(busy), 0);
    tick();
    if (drop) req_valid = 2'b00;
    for (int k = 0; k < n; k++) begin
      chk("W_walk", 32'(W), k);
      chk("J_walk", 32'(J), 32'(perm_s[eng][3*k +: 3]));
      chk("rsp_valid_run", 32'(rsp_valid), 0);
      chk("req_ready_run", 32'(req_ready), 0);
      tick();
    end
    chk("rsp_valid", 32'(rsp_valid), eng ? 2 : 1);
    chk("rsp_sum", 32'(rsp_sum), s);
    chk("rsp_abort", 32'(rsp_abort), 32'(ab));
    chk("busy_resp", 32'(busy), 1);
    w0 = W;
    j0 = J;
    s0 = rsp_sum;
    rsp_ready = eng ? 2'b01 : 2'b10;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), eng ? 2 : 1);
      chk("hold_sum", 32'(rsp_sum), 32'(s0));
      chk("hold_W", 32'(W), 32'(w0));
      chk("hold_J", 32'(J), 32'(j0));
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = eng ? 2'b10 : 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("busy_done", 32'(busy), 0);
    chk("rsp_valid_done", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [23:0] ident, rev;
    int eng;
    for (int i = 0; i < 8; i++) begin
      ident[3*i +: 3] = 3'(i);
      rev[3*i +: 3] = 3'(7 - i);
    end
    req_valid = 2'b11;
    #1 RST_N = 1'b0;
    #1 chk_zero("reset");
    req_valid = 2'b00;
    #10 RST_N = 1'b1;
    tick();
    // identity on engine 0, reversed on engine 1
    perm_s[0] = ident; bound_s[0] = 10'd1023;
    req_valid = 2'b01;
    run_job(0, 0, 1);
    perm_s[1] = rev; bound_s[1] = 10'd1023;
    req_valid = 2'b10;
    run_job(1, 0, 1);
    // early-abort bounds (full sum when the abort feature is absent)
    perm_s[0] = ident; bound_s[0] = 10'd50;
    req_valid = 2'b01;
    run_job(0, 2, 1);
    bound_s[0] = 10'd140;
    req_valid = 2'b01;
    run_job(0, 0, 1);
    // fresh reset, then a held tie alternates 0,1,0,1
    RST_N = 1'b0;
    #1 RST_N = 1'b1;
    tick();
    perm_s[0] = 24'($urandom); bound_s[0] = 10'd1023;
    perm_s[1] = 24'($urandom); bound_s[1] = 10'd1023;
    req_valid = 2'b11;
    run_job(0, 0, 0);
    run_job(1, 5, 0);
    run_job(0, 0, 0);
    run_job(1, 0, 1);
    for (int r = 0; r < 8; r++) begin
      eng = int'($urandom_range(1, 0));
      perm_s[eng] = 24'($urandom);
      bound_s[eng] = 10'($urandom_range(1023, 0));
      req_valid = eng ? 2'b10 : 2'b01;
      run_job(eng, int'($urandom_range(3, 0)), 1);
    end
    // reset in RUN cycle 4 drops the job and restores the engine-0-first rule
    perm_s[1] = 24'($urandom); bound_s[1] = 10'd1023;
    req_perm = {perm_s[1], perm_s[0]};
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("mid_busy", 32'(busy), 1);
    RST_N = 1'b0;
    #1 chk_zero("mid_reset");
    tick();
    tick();
    chk("mid_no_rsp", 32'(rsp_valid), 0);
    RST_N = 1'b1;
    tick();
    chk_zero("post_reset");
    perm_s[0] = 24'($urandom); bound_s[0] = 10'd1023;
    req_valid = 2'b11;
    run_job(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
